signed_bin_to_bcd: RTL and testbench
====================================

// Module: signed_bin_to_bcd
// PURPOSE
//   Sequential double-dabble converter: signed two's-complement product in, BCD digits plus sign out.
//   Supplies the digit, sign and significant-digit inputs of the seven-segment display driver.
//   Sits between the sequential multiplier result register and the display.
//   One iteration per clock, start/busy/done handshake; results held until the next conversion completes.
// PARAMETERS
//   WIDTH   16  input width, signed two's complement
//   DIGITS  5   BCD digits out; must hold 2^(WIDTH-1) (5 for WIDTH=16)
// PORTS
//   clk      in   1                   system clock; all state changes on rising edge
//   rst      in   1                   synchronous, active-high reset
//   start    in   1                   request conversion of din; sampled only in IDLE
//   din      in   WIDTH               signed value to convert; sampled on the accepting edge only
//   busy     out  1                   high from the accepting edge until done is asserted
//   done     out  1                   one-cycle pulse when new bcd/neg/ndigits are valid
//   bcd      out  4*DIGITS            packed BCD; [3:0] = units, [4*DIGITS-1:4*DIGITS-4] = most significant digit
//   neg      out  1                   result negative; forced 0 when value is zero (no "-0")
//   ndigits  out  $clog2(DIGITS+1)    count of significant digits, 1..DIGITS (zero -> 1)
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, bcd=0, neg=0, ndigits=1; any conversion in flight is discarded.
//   FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE
//     - start=1 at edge E0: capture sign=din[WIDTH-1] and mag=|din| (WIDTH-bit unsigned).
//     - Clear BCD scratch and iteration counter; go to SHIFT; busy=1 after E0.
//   SHIFT (edges E1..E_WIDTH)
//     - Each edge: every scratch digit >=5 gets +3.
//     - Then shift {scratch,mag} left by 1.
//     - Counter increments; after the WIDTH-th iteration go to DONE.
//   DONE (edge E_WIDTH+1)
//     - Register scratch into bcd.
//     - neg = sign & (mag_captured != 0).
//     - ndigits = index of the highest nonzero digit + 1, or 1 if all digits are zero.
//     - done=1 and busy=0 for exactly that cycle; state -> IDLE.
//   Latency: done high in the cycle following edge E0+WIDTH+1 (17 edges for WIDTH=16).
//   Outputs bcd/neg/ndigits change only at the DONE edge and stay stable otherwise.
//   start while busy: ignored and not queued; din changes while busy have no effect.
//   start high in the done cycle: accepted (state already IDLE); back-to-back throughput WIDTH+2 cycles.
//   start held high continuously: re-converts every WIDTH+2 cycles.
//   Most negative input (e.g. 16'h8000): magnitude 2^(WIDTH-1) represented exactly, no overflow.
//   rst in any state, including mid-SHIFT or DONE, overrides start and restores reset values next edge.
//   Scratch register width is 4*DIGITS; the +3 correction uses 4-bit per-digit compare only.
// TESTING
//   1. Assert rst 2 cycles -> busy=0, done=0, bcd=0, neg=0, ndigits=1.
//   2. din=16'h0000, start 1 cycle
//      -> done pulse 17 edges later, bcd=20'h00000, neg=0, ndigits=1.
//   3. din=16'hFFFF (-1) -> bcd=20'h00001, neg=1, ndigits=1.
//      Then din=16'h8000 -> bcd=20'h32768, neg=1, ndigits=5.
//   4. din=16'h3039 (12345), start.
//      Pulse start with din=16'h0007 at cycle 5
//      -> single done, bcd=20'h12345, neg=0, ndigits=5; second start ignored.
//   5. din=16'hFF9C (-100), start.
//      Re-assert start with din=16'h0063 in the done cycle
//      -> first result bcd=20'h00100, neg=1, ndigits=3.
//      -> second done after 18 more edges: bcd=20'h00099, neg=0, ndigits=2.
//   6. Start 16'h7FFF, assert rst at SHIFT iteration 8
//      -> no done, outputs at reset values.
//      Fresh start with 16'h7FFF -> bcd=20'h32767, neg=0, ndigits=5.

Source files
------------

// File: rtl/signed_bin_to_bcd.sv
// signed_bin_to_bcd: sequential double-dabble converter, signed binary in, BCD digits plus sign out
module signed_bin_to_bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIDTH-1:0]             din,
    output logic                         busy,
    output logic                         done,
    output logic [4*DIGITS-1:0]          bcd,
    output logic                         neg,
    output logic [$clog2(DIGITS+1)-1:0]  ndigits
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);
    localparam int NW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] mag;
    logic [BW-1:0]   scr, adj;
    logic            sign, nz;
    logic [NW-1:0]   nd;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = (state == IDLE)  ? (start ? SHIFT : IDLE) :
                  (state == SHIFT) ? ((cnt == LAST) ? DONE : SHIFT) : IDLE;
    end

    // +3 correction per digit before each shift
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign adj[4*d +: 4] = (scr[4*d +: 4] >= 4'd5) ? scr[4*d +: 4] + 4'd3 : scr[4*d +: 4];
    end

    always_comb begin
        nd = NW'(1);
        for (int i = 1; i < DIGITS; i++)
            if (scr[4*i +: 4] != 4'd0) nd = NW'(i + 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            bcd     <= '0;
            neg     <= 1'b0;
            ndigits <= NW'(1);
            cnt     <= '0;
            mag     <= '0;
            scr     <= '0;
            sign    <= 1'b0;
            nz      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                sign <= din[WIDTH-1];
                nz   <= |din;
                mag  <= din[WIDTH-1] ? -din : din;
                scr  <= '0;
                cnt  <= '0;
            end
            if (state == SHIFT) begin
                {scr, mag} <= {adj[BW-2:0], mag, 1'b0};
                cnt        <= cnt + 1'b1;
            end
            if (state == DONE) begin
                bcd     <= scr;
                neg     <= sign & nz;
                ndigits <= nd;
                done    <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_signed_bin_to_bcd.sv
// tb_signed_bin_to_bcd: directed self-checking bench for signed_bin_to_bcd
module tb_signed_bin_to_bcd;
    logic        clk = 1'b0;
    logic        rst, start, busy, done, neg;
    logic [15:0] din;
    logic [19:0] bcd;
    logic [2:0]  ndigits;
    int          tests = 0;
    int          fails = 0;

    signed_bin_to_bcd #(.WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .busy(busy),
        .done(done), .bcd(bcd), .neg(neg), .ndigits(ndigits)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // counts edges until done is seen, -1 if it never comes
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; din = '0;
        tick(); tick();
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h0 || neg !== 1'b0 || ndigits !== 3'd1) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b bcd=%h neg=%b nd=%0d, want 0 0 00000 0 1", busy, done, bcd, neg, ndigits);
        end
    endtask

    task automatic test_convert(input logic [15:0] v, input logic [19:0] eb, input logic en, input logic [2:0] end_);
        int n;
        din = v; start = 1'b1;
        tick();
        start = 1'b0; din = 16'hAAAA;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_start %h: busy=%b want 1", v, busy);
        end
        wait_done(n);
        tests++;
        if (n !== 17) begin
            fails++;
            $display("FAIL latency %h: edges=%0d want 17", v, n);
        end
        tests++;
        if (bcd !== eb || neg !== en || ndigits !== end_ || busy !== 1'b0) begin
            fails++;
            $display("FAIL convert %h: bcd=%h neg=%b nd=%0d busy=%b want %h %b %0d 0", v, bcd, neg, ndigits, busy, eb, en, end_);
        end
        tick();
        tests++;
        if (done !== 1'b0 || bcd !== eb) begin
            fails++;
            $display("FAIL pulse %h: done=%b bcd=%h want 0 %h", v, done, bcd, eb);
        end
    endtask

    task automatic test_start_while_busy();
        int n, extra;
        din = 16'h3039; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        din = 16'h0007; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        tests++;
        if (n !== 12) begin
            fails++;
            $display("FAIL busy_ignore_latency: edges=%0d want 12", n);
        end
        tests++;
        if (bcd !== 20'h12345 || neg !== 1'b0 || ndigits !== 3'd5) begin
            fails++;
            $display("FAIL busy_ignore: bcd=%h neg=%b nd=%0d want 12345 0 5", bcd, neg, ndigits);
        end
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done || busy) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL busy_ignore_queued: activity cycles=%0d want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        din = 16'hFF9C; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        tests++;
        if (n !== 17 || bcd !== 20'h00100 || neg !== 1'b1 || ndigits !== 3'd3) begin
            fails++;
            $display("FAIL b2b_first: edges=%0d bcd=%h neg=%b nd=%0d want 17 00100 1 3", n, bcd, neg, ndigits);
        end
        din = 16'h0063; start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || bcd !== 20'h00100) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b done=%b bcd=%h want 1 0 00100", busy, done, bcd);
        end
        wait_done(n);
        tests++;
        if (n !== 17 || bcd !== 20'h00099 || neg !== 1'b0 || ndigits !== 3'd2) begin
            fails++;
            $display("FAIL b2b_second: edges=%0d bcd=%h neg=%b nd=%0d want 17 00099 0 2", n + 1, bcd, neg, ndigits);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        din = 16'h7FFF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done || busy) seen++;
        end
        tests++;
        if (seen !== 0 || bcd !== 20'h0 || neg !== 1'b0 || ndigits !== 3'd1) begin
            fails++;
            $display("FAIL reset_mid: activity=%0d bcd=%h neg=%b nd=%0d want 0 00000 0 1", seen, bcd, neg, ndigits);
        end
    endtask

    initial begin
        test_reset();
        test_convert(16'h0000, 20'h00000, 1'b0, 3'd1);
        test_convert(16'hFFFF, 20'h00001, 1'b1, 3'd1);
        test_convert(16'h8000, 20'h32768, 1'b1, 3'd5);
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_convert(16'h7FFF, 20'h32767, 1'b0, 3'd5);
        test_convert(16'h03E8, 20'h01000, 1'b0, 3'd4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
